// File: rtl/adc_cmd_arbiter.sv
// adc_cmd_arbiter: two-requester ADC command arbiter with response routing (option: ADC_ARB_FIXED_PRIO_EN)
module adc_cmd_arbiter #(
   parameter int OWNER_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic        req0_sop,
   input  logic        req0_eop,
   input  logic [4:0]  req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic        req1_sop,
   input  logic        req1_eop,
   input  logic [4:0]  req1_data,
   output logic        req1_ready,
   output logic        cmd_valid,
   output logic        cmd_sop,
   output logic        cmd_eop,
   output logic [4:0]  cmd_data,
   input  logic        cmd_ready,
   input  logic        resp_valid,
   input  logic        resp_sop,
   input  logic        resp_eop,
   input  logic [11:0] resp_data,
   input  logic [4:0]  resp_channel,
   output logic        rsp0_valid,
   output logic        rsp0_sop,
   output logic        rsp0_eop,
   output logic [11:0] rsp0_data,
   output logic [4:0]  rsp0_channel,
   output logic        rsp1_valid,
   output logic        rsp1_sop,
   output logic        rsp1_eop,
   output logic [11:0] rsp1_data,
   output logic [4:0]  rsp1_channel,
   output logic [1:0]  grant,
   output logic        owner_full,
   output logic        orphan_err
);
   localparam int PW = (OWNER_DEPTH > 1) ? $clog2(OWNER_DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = OWNER_DEPTH[PW:0];
   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
   state_t state, state_nxt;
   logic [OWNER_DEPTH-1:0] owner_mem;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0] count;
   logic sel, push, pop, empty, head;
`ifdef ADC_ARB_FIXED_PRIO_EN
   assign sel = !req0_valid;
`else
   logic last_granted;
   assign sel = (req0_valid && req1_valid) ? !last_granted : (req1_valid && !req0_valid);
   // remember who won so the other side wins the next tie
   always_ff @(posedge clk) begin
      if (reset) last_granted <= 1'b1;
      else if (push) last_granted <= sel;
   end
`endif
   assign empty = (count == '0);
   assign owner_full = (count == FULL_CNT);
   assign head = owner_mem[rd_ptr];
   assign pop = resp_valid && resp_eop && !empty;
   assign grant = {state == GRANT1, state == GRANT0};
   assign rsp0_valid = resp_valid && !empty && !head;
   assign rsp1_valid = resp_valid && !empty && head;
   assign rsp0_sop = resp_sop;
   assign rsp0_eop = resp_eop;
   assign rsp0_data = resp_data;
   assign rsp0_channel = resp_channel;
   assign rsp1_sop = resp_sop;
   assign rsp1_eop = resp_eop;
   assign rsp1_data = resp_data;
   assign rsp1_channel = resp_channel;
   // arbitration state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_nxt;
   end
   // grant selection and zero-latency command muxing for the granted requester
   always_comb begin
      state_nxt = state;
      push = 1'b0;
      cmd_valid = 1'b0;
      cmd_sop = 1'b0;
      cmd_eop = 1'b0;
      cmd_data = '0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            if ((req0_valid || req1_valid) && !owner_full) begin
               state_nxt = sel ? GRANT1 : GRANT0;
               push = 1'b1;
            end
         end
         GRANT0: begin
            cmd_valid = req0_valid;
            cmd_sop = req0_sop;
            cmd_eop = req0_eop;
            cmd_data = req0_data;
            req0_ready = cmd_ready;
            if (req0_valid && cmd_ready && req0_eop) state_nxt = IDLE;
         end
         GRANT1: begin
            cmd_valid = req1_valid;
            cmd_sop = req1_sop;
            cmd_eop = req1_eop;
            cmd_data = req1_data;
            req1_ready = cmd_ready;
            if (req1_valid && cmd_ready && req1_eop) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
   // owner FIFO: id pushed on each grant, popped on each response eop
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            owner_mem[wr_ptr] <= sel;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end
   // sticky flag for responses that arrive with no outstanding owner
   always_ff @(posedge clk) begin
      if (reset) orphan_err <= 1'b0;
      else if (resp_valid && empty) orphan_err <= 1'b1;
   end
endmodule

// File: tb/tb_adc_cmd_arbiter.sv
// tb_adc_cmd_arbiter: vector table, directed corner cases and a queue-model random run
module tb_adc_cmd_arbiter;
   localparam int D = 4;
`ifdef ADC_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   logic clk, reset;
   logic req0_valid, req0_sop, req0_eop, req0_ready;
   logic req1_valid, req1_sop, req1_eop, req1_ready;
   logic [4:0] req0_data, req1_data, cmd_data, resp_channel, rsp0_channel, rsp1_channel;
   logic cmd_valid, cmd_sop, cmd_eop, cmd_ready;
   logic resp_valid, resp_sop, resp_eop;
   logic [11:0] resp_data, rsp0_data, rsp1_data;
   logic rsp0_valid, rsp0_sop, rsp0_eop, rsp1_valid, rsp1_sop, rsp1_eop;
   logic [1:0] grant;
   logic owner_full, orphan_err;
   int tests = 0;
   int fails = 0;

   adc_cmd_arbiter #(.OWNER_DEPTH(D)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_sop(req0_sop), .req0_eop(req0_eop), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_sop(req1_sop), .req1_eop(req1_eop), .req1_data(req1_data), .req1_ready(req1_ready),
      .cmd_valid(cmd_valid), .cmd_sop(cmd_sop), .cmd_eop(cmd_eop), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
      .resp_valid(resp_valid), .resp_sop(resp_sop), .resp_eop(resp_eop), .resp_data(resp_data), .resp_channel(resp_channel),
      .rsp0_valid(rsp0_valid), .rsp0_sop(rsp0_sop), .rsp0_eop(rsp0_eop), .rsp0_data(rsp0_data), .rsp0_channel(rsp0_channel),
      .rsp1_valid(rsp1_valid), .rsp1_sop(rsp1_sop), .rsp1_eop(rsp1_eop), .rsp1_data(rsp1_data), .rsp1_channel(rsp1_channel),
      .grant(grant), .owner_full(owner_full), .orphan_err(orphan_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req0_sop = 0; req0_eop = 0; req0_data = 5'h0A;
      req1_valid = 0; req1_sop = 0; req1_eop = 0; req1_data = 5'h15;
      cmd_ready = 0;
      resp_valid = 0; resp_sop = 0; resp_eop = 0; resp_data = '0; resp_channel = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      tick();
      reset = 0;
   endtask

   typedef struct {
      logic r0v, r0e, r1v, r1e, crdy;
      logic [1:0] g;
      logic cv, rd0, rd1;
   } vec_t;
   vec_t vt[10];

   logic [1:0] eg;
   logic [11:0] d;
   int owners[3];
   int found;

   int cur, last;
   int q[$];
   bit orph;

   initial begin
      // 3-beat packets from both requesters with cmd_ready held high
      vt[0] = '{1,0,1,0,1, 2'b00, 0,0,0};
      vt[1] = '{1,0,1,0,1, 2'b01, 1,1,0};
      vt[2] = '{1,0,1,0,1, 2'b01, 1,1,0};
      vt[3] = '{1,1,1,1,1, 2'b01, 1,1,0};
      vt[4] = '{1,0,1,0,1, 2'b00, 0,0,0};
      vt[5] = '{1,0,1,0,1, 2'b10, 1,0,1};
      vt[6] = '{1,0,1,0,1, 2'b10, 1,0,1};
      vt[7] = '{1,1,1,1,1, 2'b10, 1,0,1};
      vt[8] = '{1,0,1,0,1, 2'b00, 0,0,0};
      vt[9] = '{1,0,1,0,1, 2'b01, 1,1,0};

      reset = 0;
      do_reset();
      chk("reset_grant", grant, 2'b00);
      chk("reset_cmd_valid", cmd_valid, 0);
      chk("reset_owner_full", owner_full, 0);
      chk("reset_orphan", orphan_err, 0);
      chk("reset_ready", {req0_ready, req1_ready}, 2'b00);

      for (int i = 0; i < 10; i++) begin
         vec_t v;
         v = vt[i];
         if (FIXED && v.g == 2'b10) begin
            v.g = 2'b01; v.rd0 = 1; v.rd1 = 0;
         end
         req0_valid = v.r0v; req0_eop = v.r0e; req0_sop = 0;
         req1_valid = v.r1v; req1_eop = v.r1e; req1_sop = 0;
         cmd_ready = v.crdy;
         settle();
         chk($sformatf("vec%0d_grant", i), grant, v.g);
         chk($sformatf("vec%0d_cmd_valid", i), cmd_valid, v.cv);
         chk($sformatf("vec%0d_ready", i), {req0_ready, req1_ready}, {v.rd0, v.rd1});
         if (v.cv) chk($sformatf("vec%0d_cmd_data", i), cmd_data, v.g[1] ? 5'h15 : 5'h0A);
         tick();
      end

      // req0 stalled mid-packet while req1 waits
      do_reset();
      req0_valid = 1; req1_valid = 1; cmd_ready = 1;
      tick();
      settle();
      chk("stall_first_grant", grant, 2'b01);
      tick();
      cmd_ready = 0; req0_eop = 1;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("stall_grant", grant, 2'b01);
         chk("stall_req1_ready", req1_ready, 0);
         chk("stall_cmd_data", cmd_data, 5'h0A);
         tick();
      end
      cmd_ready = 1;
      settle();
      chk("stall_release_req1_ready", req1_ready, 0);
      chk("stall_release_eop", cmd_eop, 1);
      tick();
      req0_eop = 0;
      settle();
      chk("stall_idle", grant, 2'b00);
      tick();
      chk("stall_next_grant", grant, FIXED ? 2'b01 : 2'b10);

      // owner FIFO fills after four unanswered packets
      do_reset();
      req0_valid = 1; req0_sop = 1; req0_eop = 1; cmd_ready = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         tick();
      end
      settle();
      chk("full_flag", owner_full, 1);
      for (int i = 0; i < 3; i++) begin
         chk("full_held_idle", grant, 2'b00);
         tick();
      end
      resp_valid = 1; resp_sop = 1; resp_eop = 1; resp_data = 12'hABC; resp_channel = 5'd3;
      settle();
      chk("full_rsp0_valid", rsp0_valid, 1);
      tick();
      resp_valid = 0;
      settle();
      chk("full_cleared", owner_full, 0);
      found = 0;
      for (int i = 0; i < 3 && found == 0; i++) begin
         if (grant == 2'b01) found = 1;
         else tick();
      end
      chk("full_grant_after_pop", found, 1);

      // grants 0,1,0 then three 3-beat responses routed in order
      do_reset();
      req0_valid = 1; req1_valid = 1; req0_sop = 1; req0_eop = 1; req1_sop = 1; req1_eop = 1; cmd_ready = 1;
      for (int i = 0; i < 6; i++) begin
         settle();
         eg = (i % 2 == 0) ? 2'b00 : ((i == 3 && !FIXED) ? 2'b10 : 2'b01);
         chk($sformatf("order_grant%0d", i), grant, eg);
         tick();
      end
      req0_valid = 0; req1_valid = 0;
      owners[0] = 0; owners[1] = FIXED ? 0 : 1; owners[2] = 0;
      for (int r = 0; r < 3; r++) begin
         for (int b = 0; b < 3; b++) begin
            d = (b == 1) ? 12'h123 : 12'($urandom);
            resp_valid = 1; resp_sop = (b == 0); resp_eop = (b == 2); resp_data = d; resp_channel = 5'(r + 4);
            settle();
            chk($sformatf("route%0d_rsp0_valid", r), rsp0_valid, owners[r] == 0);
            chk($sformatf("route%0d_rsp1_valid", r), rsp1_valid, owners[r] == 1);
            chk($sformatf("route%0d_data", r), owners[r] ? rsp1_data : rsp0_data, d);
            chk($sformatf("route%0d_channel", r), owners[r] ? rsp1_channel : rsp0_channel, r + 4);
            chk($sformatf("route%0d_eop", r), owners[r] ? rsp1_eop : rsp0_eop, b == 2);
            tick();
         end
      end
      resp_valid = 0;
      settle();
      chk("route_no_orphan", orphan_err, 0);

      // response with nothing outstanding
      do_reset();
      resp_valid = 1; resp_eop = 0;
      settle();
      chk("orphan_rsp_valids", {rsp0_valid, rsp1_valid}, 2'b00);
      tick();
      resp_valid = 0;
      settle();
      chk("orphan_set", orphan_err, 1);
      tick(); tick(); tick();
      chk("orphan_sticky", orphan_err, 1);
      do_reset();
      chk("orphan_reset_clears", orphan_err, 0);

      // reset in the middle of a req1 packet
      do_reset();
      req1_valid = 1; req1_data = 5'h11; cmd_ready = 1;
      tick();
      chk("midreset_grant1", grant, 2'b10);
      tick();
      reset = 1;
      tick();
      reset = 0; req1_valid = 0;
      settle();
      chk("midreset_grant", grant, 2'b00);
      chk("midreset_cmd_valid", cmd_valid, 0);
      chk("midreset_owner_full", owner_full, 0);
      resp_valid = 1; resp_eop = 1;
      settle();
      chk("midreset_fifo_empty", rsp1_valid, 0);
      resp_valid = 0; resp_eop = 0;
      req1_valid = 1; req1_sop = 1;
      settle();
      tick();
      chk("midreset_clean_grant", grant, 2'b10);
      chk("midreset_clean_data", cmd_data, 5'h11);
      chk("midreset_clean_sop", cmd_sop, 1);

      // random traffic against an owner-queue model
      do_reset();
      cur = -1; last = 1; orph = 0; q.delete();
      for (int c = 0; c < 600; c++) begin
         int sz, pick;
         logic e0v, e1v;
         req0_valid = ($urandom_range(0, 3) != 0); req0_sop = 1'($urandom); req0_eop = ($urandom_range(0, 2) == 0); req0_data = 5'($urandom);
         req1_valid = ($urandom_range(0, 3) != 0); req1_sop = 1'($urandom); req1_eop = ($urandom_range(0, 2) == 0); req1_data = 5'($urandom);
         cmd_ready = ($urandom_range(0, 3) != 0);
         resp_valid = ($urandom_range(0, 2) == 0); resp_sop = 1'($urandom); resp_eop = 1'($urandom);
         resp_data = 12'($urandom); resp_channel = 5'($urandom);
         settle();
         sz = q.size();
         chk("rnd_grant", grant, cur == 0 ? 2'b01 : cur == 1 ? 2'b10 : 2'b00);
         chk("rnd_cmd_valid", cmd_valid, cur == 0 ? req0_valid : cur == 1 ? req1_valid : 1'b0);
         chk("rnd_ready", {req0_ready, req1_ready}, {cur == 0 && cmd_ready, cur == 1 && cmd_ready});
         if (cur >= 0) chk("rnd_cmd_data", {cmd_sop, cmd_eop, cmd_data}, cur ? {req1_sop, req1_eop, req1_data} : {req0_sop, req0_eop, req0_data});
         chk("rnd_owner_full", owner_full, sz == D);
         chk("rnd_orphan", orphan_err, orph);
         e0v = resp_valid && sz > 0 && q[0] == 0;
         e1v = resp_valid && sz > 0 && q[0] == 1;
         chk("rnd_rsp_valid", {rsp0_valid, rsp1_valid}, {e0v, e1v});
         chk("rnd_rsp_data", {rsp0_data, rsp1_channel, rsp1_eop}, {resp_data, resp_channel, resp_eop});
         if (cur >= 0) begin
            if ((cur ? req1_valid && req1_eop : req0_valid && req0_eop) && cmd_ready) cur = -1;
         end else if ((req0_valid || req1_valid) && sz < D) begin
            pick = (req0_valid && req1_valid) ? (FIXED ? 0 : 1 - last) : (req1_valid ? 1 : 0);
            cur = pick;
            last = pick;
            q.push_back(pick);
         end
         if (resp_valid && sz == 0) orph = 1;
         if (resp_valid && resp_eop && sz > 0) void'(q.pop_front());
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
